// File: rtl/pa_dcache_array_ctrl_pkg.sv
// pa_dcache_pkg: shared defaults, FSM encoding and tag layout for the dcache array controller
package pa_dcache_pkg;
  localparam int WAYS_DEF = 2;
  localparam int BANKS_DEF = 2;
  localparam int SETS_DEF = 1024;
  localparam int TAG_W_DEF = 23;
  localparam int TAG_VLD_BIT = TAG_W_DEF - 1;
  typedef enum logic {IDLE, SWEEP} state_e;
endpackage

// File: rtl/pa_dcache_array_ctrl_if.sv
// pa_dcache_array_ctrl_if: access, response and invalidate signals of the dcache arrays
interface pa_dcache_array_ctrl_if import pa_dcache_pkg::*; #(
  parameter int WAYS = WAYS_DEF,
  parameter int BANKS = BANKS_DEF,
  parameter int SETS = SETS_DEF,
  parameter int TAG_W = TAG_W_DEF
);
  localparam int IW = $clog2(SETS);
  logic req_vld;
  logic req_rdy;
  logic req_wr;
  logic [IW-1:0] req_idx;
  logic [WAYS-1:0] req_tag_we;
  logic [TAG_W-1:0] req_tag_din;
  logic [WAYS-1:0] req_dirty_we;
  logic req_dirty_din;
  logic [WAYS*BANKS-1:0] req_bank_en;
  logic [4*BANKS-1:0] req_data_be;
  logic [32*BANKS-1:0] req_data_din;
  logic rsp_vld;
  logic [WAYS*TAG_W-1:0] rsp_tag_dout;
  logic [WAYS-1:0] rsp_dirty_dout;
  logic [WAYS*BANKS*32-1:0] rsp_data_dout;
  logic inv_req;
  logic inv_busy;
  logic inv_done;
  modport master (
    output req_vld, req_wr, req_idx, req_tag_we, req_tag_din, req_dirty_we, req_dirty_din,
           req_bank_en, req_data_be, req_data_din, inv_req,
    input  req_rdy, rsp_vld, rsp_tag_dout, rsp_dirty_dout, rsp_data_dout, inv_busy, inv_done
  );
  modport slave (
    input  req_vld, req_wr, req_idx, req_tag_we, req_tag_din, req_dirty_we, req_dirty_din,
           req_bank_en, req_data_be, req_data_din, inv_req,
    output req_rdy, rsp_vld, rsp_tag_dout, rsp_dirty_dout, rsp_data_dout, inv_busy, inv_done
  );
endinterface

// File: rtl/pa_dcache_sram_bank.sv
// pa_dcache_sram_bank: single-port SRAM model, 1-cycle read, bit-masked write
module pa_dcache_sram_bank #(
  parameter int DW = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     ce_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DW-1:0]            mask_i,
  input  logic [DW-1:0]            din_i,
  output logic [DW-1:0]            dout_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dout_q;
  // enabled write merges masked bits; enabled read registers the addressed word
  always_ff @(posedge clk) begin
    if (ce_i && we_i) mem_q[addr_i] <= (mem_q[addr_i] & ~mask_i) | (din_i & mask_i);
    else if (ce_i) dout_q <= mem_q[addr_i];
  end
  assign dout_o = dout_q;
endmodule

// File: rtl/pa_dcache_array_ctrl.sv
// pa_dcache_array_ctrl: dcache tag/dirty/data array access control with invalidate-all sweep
module pa_dcache_array_ctrl import pa_dcache_pkg::*; #(
  parameter int WAYS = WAYS_DEF,
  parameter int BANKS = BANKS_DEF,
  parameter int SETS = SETS_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic forever_cpuclk,
  input logic cpurst,
  pa_dcache_array_ctrl_if.slave bus
);
  localparam int IW = $clog2(SETS);
  state_e state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, addr;
  logic rsp_vld_q, sweep, last, rd, wr;
  assign sweep = state_q == SWEEP;
  assign last = cnt_q == IW'(SETS - 1);
  assign bus.req_rdy = state_q == IDLE && !bus.inv_req && !cpurst;
  assign rd = bus.req_vld && bus.req_rdy && !bus.req_wr;
  assign wr = bus.req_vld && bus.req_rdy && bus.req_wr;
  assign addr = sweep ? cnt_q : bus.req_idx;
  assign bus.inv_busy = sweep;
  assign bus.inv_done = sweep && last && !cpurst;
  assign bus.rsp_vld = rsp_vld_q;
  // sweep walks every set once then idles; invalidate requests only start a sweep from idle
  always_comb begin
    state_d = sweep ? (last ? IDLE : SWEEP) : (bus.inv_req ? SWEEP : IDLE);
    cnt_d = sweep ? cnt_q + 1'b1 : '0;
  end
  // reset always restarts the sweep from set 0
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= SWEEP;
      cnt_q <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_vld_q <= rd;
    end
  end
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    pa_dcache_sram_bank #(.DW(TAG_W), .DEPTH(SETS)) u_tag (
      .clk(forever_cpuclk), .ce_i(sweep || rd || (wr && bus.req_tag_we[w])), .we_i(sweep || wr),
      .addr_i(addr), .mask_i('1), .din_i(sweep ? '0 : bus.req_tag_din),
      .dout_o(bus.rsp_tag_dout[w*TAG_W +: TAG_W])
    );
    pa_dcache_sram_bank #(.DW(1), .DEPTH(SETS)) u_dirty (
      .clk(forever_cpuclk), .ce_i(sweep || rd || (wr && bus.req_dirty_we[w])), .we_i(sweep || wr),
      .addr_i(addr), .mask_i(1'b1), .din_i(sweep ? 1'b0 : bus.req_dirty_din),
      .dout_o(bus.rsp_dirty_dout[w])
    );
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [31:0] bmask;
      for (genvar k = 0; k < 4; k++) begin : g_byte
        assign bmask[k*8 +: 8] = {8{bus.req_data_be[b*4+k]}};
      end
      pa_dcache_sram_bank #(.DW(32), .DEPTH(SETS)) u_data (
        .clk(forever_cpuclk),
        .ce_i(bus.req_bank_en[w*BANKS+b] && (rd || (wr && |bus.req_data_be[b*4 +: 4]))),
        .we_i(wr), .addr_i(addr), .mask_i(bmask), .din_i(bus.req_data_din[b*32 +: 32]),
        .dout_o(bus.rsp_data_dout[(w*BANKS+b)*32 +: 32])
      );
    end
  end
endmodule

// File: tb/tb_pa_dcache_array_ctrl.sv
// tb_pa_dcache_array_ctrl: table vectors, randomized accesses vs array model, sweep/reset sequences
module tb_pa_dcache_array_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pa_dcache_array_ctrl_if #(.WAYS(2), .BANKS(2), .SETS(16), .TAG_W(23)) bus ();
  pa_dcache_array_ctrl #(.WAYS(2), .BANKS(2), .SETS(16), .TAG_W(23)) dut (
    .forever_cpuclk(clk), .cpurst(rst), .bus(bus)
  );
  typedef struct {
    bit wr; logic [3:0] idx; logic [1:0] twe; logic [22:0] tag; logic [1:0] dwe; logic dirty;
    logic [3:0] ben; logic [7:0] be; logic [63:0] din;
    logic [45:0] etag; logic [1:0] edirty; logic [127:0] edata;
  } vec_t;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [22:0] tag_m [2][16];
  logic dirty_m [2][16];
  logic [31:0] data_m [2][2][16];
  vec_t tbl [8];
  always @(posedge clk) if (bus.inv_done) done_cnt++;
  function automatic vec_t mk(bit wr, logic [3:0] idx, logic [1:0] twe, logic [22:0] tag,
                              logic [1:0] dwe, logic dirty, logic [3:0] ben, logic [7:0] be,
                              logic [63:0] din, logic [45:0] etag, logic [1:0] edirty,
                              logic [127:0] edata);
    vec_t v;
    v.wr = wr; v.idx = idx; v.twe = twe; v.tag = tag; v.dwe = dwe; v.dirty = dirty;
    v.ben = ben; v.be = be; v.din = din; v.etag = etag; v.edirty = edirty; v.edata = edata;
    return v;
  endfunction
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic model_sweep();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin
        tag_m[w][s] = '0;
        dirty_m[w][s] = 1'b0;
      end
  endtask
  task automatic model_write(input vec_t v);
    for (int w = 0; w < 2; w++) begin
      if (v.twe[w]) tag_m[w][v.idx] = v.tag;
      if (v.dwe[w]) dirty_m[w][v.idx] = v.dirty;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 4; k++)
          if (v.ben[w*2+b] && v.be[b*4+k])
            data_m[w][b][v.idx][k*8 +: 8] = v.din[b*32+k*8 +: 8];
    end
  endtask
  task automatic access(input vec_t v, input bit use_tbl);
    logic [127:0] dmask, edata;
    logic [45:0] etag;
    logic [1:0] edirty;
    @(negedge clk);
    chk("rsp_vld_idle", 128'(bus.rsp_vld), 128'(0));
    bus.req_vld = 1'b1; bus.req_wr = v.wr; bus.req_idx = v.idx;
    bus.req_tag_we = v.twe; bus.req_tag_din = v.tag; bus.req_dirty_we = v.dwe;
    bus.req_dirty_din = v.dirty; bus.req_bank_en = v.ben; bus.req_data_be = v.be;
    bus.req_data_din = v.din;
    #1 chk("req_rdy", 128'(bus.req_rdy), 128'(1));
    @(negedge clk);
    bus.req_vld = 1'b0;
    chk("rsp_vld", 128'(bus.rsp_vld), 128'(!v.wr));
    if (!v.wr) begin
      etag = {tag_m[1][v.idx], tag_m[0][v.idx]};
      edirty = {dirty_m[1][v.idx], dirty_m[0][v.idx]};
      for (int i = 0; i < 4; i++) begin
        dmask[i*32 +: 32] = {32{v.ben[i]}};
        edata[i*32 +: 32] = data_m[i/2][i%2][v.idx];
      end
      if (use_tbl) begin
        etag = v.etag; edirty = v.edirty; edata = v.edata;
      end
      chk("rd_tag", 128'(bus.rsp_tag_dout), 128'(etag));
      chk("rd_dirty", 128'(bus.rsp_dirty_dout), 128'(edirty));
      chk("rd_data", bus.rsp_data_dout & dmask, edata & dmask);
    end else model_write(v);
  endtask
  task automatic sweep_chk(input string n);
    int d0 = done_cnt;
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk({n, "_busy"}, 128'(bus.inv_busy), 128'(1));
      chk({n, "_rdy"}, 128'(bus.req_rdy), 128'(0));
      chk({n, "_done"}, 128'(bus.inv_done), 128'(c == 16));
      if (c == 16) bus.inv_req = 1'b0;
      @(negedge clk);
    end
    #1;
    chk({n, "_idle_busy"}, 128'(bus.inv_busy), 128'(0));
    chk({n, "_idle_rdy"}, 128'(bus.req_rdy), 128'(1));
    chk({n, "_done_count"}, 128'(done_cnt - d0), 128'(1));
    model_sweep();
  endtask
  task automatic rand_ops(input int n, input bit only_rd);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = mk(only_rd ? 1'b0 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)), 23'($urandom), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
             {$urandom(), $urandom()}, '0, '0, '0);
      access(v, 1'b0);
    end
  endtask
  initial begin
    int d0;
    bus.req_vld = 0; bus.req_wr = 0; bus.req_idx = 0; bus.req_tag_we = 0; bus.req_tag_din = 0;
    bus.req_dirty_we = 0; bus.req_dirty_din = 0; bus.req_bank_en = 0; bus.req_data_be = 0;
    bus.req_data_din = 0; bus.inv_req = 0;
    tbl[0] = mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 46'h0, 2'b00, 0);
    tbl[1] = mk(1, 3, 2'b10, 23'h412345, 2'b10, 1, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 3, 0, 0, 0, 0, 0, 0, 0, {23'h412345, 23'h0}, 2'b10, 0);
    tbl[3] = mk(1, 3, 0, 0, 0, 0, 4'hF, 8'hFF, {32'h11223344, 32'h55667788}, 0, 0, 0);
    tbl[4] = mk(1, 3, 0, 0, 0, 0, 4'b0010, 8'h10, {32'hAABBCCDD, 32'hAABBCCDD}, 0, 0, 0);
    tbl[5] = mk(0, 3, 0, 0, 0, 0, 4'hF, 0, 0, {23'h412345, 23'h0}, 2'b10,
                128'h11223344_55667788_112233DD_55667788);
    tbl[6] = mk(1, 3, 2'b01, 23'h7FFFFF, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    tbl[7] = mk(0, 3, 0, 0, 0, 0, 4'b0110, 0, 0, {23'h412345, 23'h7FFFFF}, 2'b00,
                128'h11223344_55667788_112233DD_55667788);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sweep_chk("por");
    for (int i = 0; i < 8; i++) access(tbl[i], 1'b1);
    for (int s = 0; s < 16; s++)
      access(mk(1, 4'(s), 0, 0, 0, 0, 4'hF, 8'hFF, {$urandom(), $urandom()}, 0, 0, 0), 1'b0);
    rand_ops(150, 1'b0);
    @(negedge clk);
    bus.inv_req = 1'b1; bus.req_vld = 1'b1; bus.req_wr = 1'b0;
    #1 chk("conflict_rdy", 128'(bus.req_rdy), 128'(0));
    @(negedge clk);
    bus.inv_req = 1'b0; bus.req_vld = 1'b0;
    chk("conflict_no_rsp", 128'(bus.rsp_vld), 128'(0));
    sweep_chk("inv");
    rand_ops(8, 1'b1);
    rand_ops(30, 1'b0);
    @(negedge clk);
    bus.inv_req = 1'b1;
    @(negedge clk);
    sweep_chk("held");
    rand_ops(8, 1'b1);
    rand_ops(30, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("partial_no_done", 128'(done_cnt - d0), 128'(0));
    sweep_chk("rst_mid");
    rand_ops(10, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
